// File: rtl/sema_pkg.sv
// Shared types and default parameters for the semaphore arbiter.
package sema_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED  = 2'd1,
    RELEASE = 2'd2
  } sema_state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_SIZE    = 8;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/sema_arbiter_if.sv
// Requester-side bus of the semaphore arbiter: lock requests, releases, writes and lock status.
interface sema_arbiter_if #(
  parameter int NREQ = sema_pkg::DEF_NREQ,
  parameter int SIZE = sema_pkg::DEF_SIZE
);
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // req is a level held by a requester wanting the lock; rel is a one-cycle
  // pulse honoured only from the current owner; wr_en/wr_data write the shared
  // register only from the owner while locked. All are sampled on rising clk.
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      rel;
  logic [NREQ-1:0]      wr_en;
  logic [NREQ*SIZE-1:0] wr_data;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [OW-1:0]        owner;
  logic [SIZE-1:0]      reg_q;
  logic                 revoked;

  modport master (
    output req, rel, wr_en, wr_data,
    input  gnt, busy, owner, reg_q, revoked
  );

  modport slave (
    input  req, rel, wr_en, wr_data,
    output gnt, busy, owner, reg_q, revoked
  );
endinterface

// File: rtl/sema_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after the pointer.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int OW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   ptr_i,
  output logic            valid_o,
  output logic [OW-1:0]   idx_o
);

  int j;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = OW'(j);
      end
    end
  end

endmodule

// File: rtl/sema_arbiter.sv
// Semaphore arbiter: round-robin lock over NREQ requesters guarding one shared register,
// with idle-hold timeout that forcibly revokes a silent owner.
module sema_arbiter
  import sema_pkg::*;
#(
  parameter int              NREQ    = DEF_NREQ,
  parameter int              SIZE    = DEF_SIZE,
  parameter logic [SIZE-1:0] SET     = '0,
  parameter int              TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 Reset,
  sema_arbiter_if.slave        bus,
  output sema_state_e          state_o
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  sema_state_e     state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            revoked_q, revoked_d;
  logic [SIZE-1:0] reg_q, reg_d;

  logic            pick_valid;
  logic [OW-1:0]   pick_idx;
  logic            owner_wr;
  logic            owner_rel;
  logic            timeout;

  rr_picker #(.NREQ(NREQ), .OW(OW)) u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign owner_wr  = bus.wr_en[owner_q];
  assign owner_rel = bus.rel[owner_q];
  // A write or release in the same cycle counts as activity and defeats the timeout.
  assign timeout   = (TIMEOUT > 0) && (cnt_q == CNT_MAX) && !owner_wr && !owner_rel;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      revoked_q <= 1'b0;
      reg_q     <= SET;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      revoked_q <= revoked_d;
      reg_q     <= reg_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    revoked_d = 1'b0;
    reg_d     = reg_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = LOCKED;
          gnt_d   = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (owner_wr) begin
          reg_d = bus.wr_data[int'(owner_q)*SIZE +: SIZE];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (owner_rel || timeout) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          ptr_d     = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
          revoked_d = timeout;
        end
      end
      RELEASE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q == LOCKED);
  assign bus.owner   = owner_q;
  assign bus.reg_q   = reg_q;
  assign bus.revoked = revoked_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sema_arbiter.sv
// Directed bench for sema_arbiter (NREQ=4, SIZE=8, SET=0, TIMEOUT=16).
module tb_sema_arbiter;
  import sema_pkg::*;

  logic        clk;
  logic        Reset;
  sema_state_e state;
  int          n_cmp;
  int          n_bad;

  sema_arbiter_if #(.NREQ(4), .SIZE(8)) bus ();

  sema_arbiter #(.NREQ(4), .SIZE(8), .SET(8'h00), .TIMEOUT(16)) dut (
    .clk     (clk),
    .Reset   (Reset),
    .bus     (bus),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req     = '0;
    bus.rel     = '0;
    bus.wr_en   = '0;
    bus.wr_data = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    idle_inputs();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    Reset = 1'b1;
    idle_inputs();
    step();
    step();

    // Reset state
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_owner", 32'(bus.owner), 32'h0);
    chk("rst_reg", 32'(bus.reg_q), 32'h00);
    chk("rst_revoked", 32'(bus.revoked), 32'h0);
    chk("rst_state", 32'(state), 32'(IDLE));
    Reset = 1'b0;

    // Single requester, one-cycle grant latency
    bus.req = 4'b0001;
    step();
    chk("t1_gnt", 32'(bus.gnt), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    chk("t1_owner", 32'(bus.owner), 32'h0);
    chk("t1_reg", 32'(bus.reg_q), 32'h00);
    bus.rel = 4'b0001;
    bus.req = 4'b0000;
    step();
    chk("t1_rel_gnt", 32'(bus.gnt), 32'h0);
    chk("t1_rel_state", 32'(state), 32'(RELEASE));
    bus.rel = '0;
    step();
    chk("t1_idle_state", 32'(state), 32'(IDLE));

    // Round-robin order 0,1,2,3,0 with all requesting
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'h1 << (k % 4));
      chk($sformatf("rr%0d_owner", k), 32'(bus.owner), 32'(k % 4));
      step();
      chk($sformatf("rr%0d_hold", k), 32'(bus.gnt), 32'h1 << (k % 4));
      bus.rel = 4'(1 << (k % 4));
      step();
      chk($sformatf("rr%0d_dead_gnt", k), 32'(bus.gnt), 32'h0);
      chk($sformatf("rr%0d_dead_busy", k), 32'(bus.busy), 32'h0);
      bus.rel = '0;
      step();
      chk($sformatf("rr%0d_idle_gnt", k), 32'(bus.gnt), 32'h0);
      step();
    end
    bus.req = '0;

    // Owner 2 write beats a concurrent non-owner write
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("wr_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    step();
    chk("wr_req_drop_busy", 32'(bus.busy), 32'h1);
    bus.wr_en = 4'b0110;
    bus.wr_data[2*8 +: 8] = 8'hA5;
    bus.wr_data[1*8 +: 8] = 8'h3C;
    step();
    chk("wr_owner_wins", 32'(bus.reg_q), 32'hA5);
    bus.wr_en = 4'b0010;
    step();
    chk("wr_nonowner_ignored", 32'(bus.reg_q), 32'hA5);
    bus.wr_en = 4'b0000;
    bus.rel = 4'b0100;
    step();
    bus.rel = 4'b0000;
    bus.wr_en = 4'b0100;
    bus.wr_data[2*8 +: 8] = 8'h77;
    step();
    chk("wr_outside_locked", 32'(bus.reg_q), 32'hA5);
    idle_inputs();

    // Idle-hold timeout revokes owner 0, then requester 1 gets the lock
    do_reset();
    bus.req = 4'b0011;
    step();
    chk("to_gnt0", 32'(bus.gnt), 32'h1);
    for (int k = 0; k < 15; k++) step();
    chk("to_last_held", 32'(bus.gnt), 32'h1);
    chk("to_no_early_revoke", 32'(bus.revoked), 32'h0);
    step();
    chk("to_revoked", 32'(bus.revoked), 32'h1);
    chk("to_revoked_gnt", 32'(bus.gnt), 32'h0);
    step();
    chk("to_revoked_pulse", 32'(bus.revoked), 32'h0);
    chk("to_idle_gnt", 32'(bus.gnt), 32'h0);
    step();
    chk("to_next_gnt", 32'(bus.gnt), 32'h2);

    // Non-owner release ignored; owner write coincident with release accepted
    do_reset();
    bus.req = 4'b0001;
    step();
    chk("rw_gnt", 32'(bus.gnt), 32'h1);
    bus.rel = 4'b1000;
    step();
    chk("rw_nonowner_rel_busy", 32'(bus.busy), 32'h1);
    chk("rw_nonowner_rel_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    bus.rel = 4'b0001;
    bus.wr_en = 4'b0001;
    bus.wr_data[0 +: 8] = 8'h5A;
    step();
    chk("rw_reg", 32'(bus.reg_q), 32'h5A);
    chk("rw_gnt_after", 32'(bus.gnt), 32'h0);
    chk("rw_revoked", 32'(bus.revoked), 32'h0);

    // Reset while locked with owner write pending
    idle_inputs();
    bus.req = 4'b0010;
    step();
    step();
    chk("rl_gnt", 32'(bus.gnt), 32'h2);
    bus.wr_en = 4'b0010;
    bus.wr_data[1*8 +: 8] = 8'hFF;
    Reset = 1'b1;
    step();
    chk("rl_reg", 32'(bus.reg_q), 32'h00);
    chk("rl_gnt_after", 32'(bus.gnt), 32'h0);
    chk("rl_busy", 32'(bus.busy), 32'h0);
    chk("rl_owner", 32'(bus.owner), 32'h0);
    chk("rl_state", 32'(state), 32'(IDLE));
    Reset = 1'b0;
    idle_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
